four_bit_ripple_adder: RTL and testbench

//   Registered 4-bit ripple-carry adder: {cout,s} = a + b + cin, captured on clk.

---
 rtl/four_bit_ripple_adder_pkg.sv | 14 +
 rtl/four_bit_ripple_adder_if.sv | 33 +++
 rtl/four_bit_ripple_adder_fa.sv | 16 +
 rtl/four_bit_ripple_adder.sv | 83 ++++++++
 tb/tb_four_bit_ripple_adder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/four_bit_ripple_adder_pkg.sv
// Shared types for the registered ripple-carry adder (package adder_pkg).
// Optional signed-overflow output is enabled with ADDER_OVERFLOW_EN.
package adder_pkg;

   localparam int ADDER_WIDTH = 4;

   typedef logic [ADDER_WIDTH-1:0] nibble_t;

   typedef struct packed {
      nibble_t s;
      logic    cout;
   } add_result_t;

endpackage

// File: rtl/four_bit_ripple_adder_if.sv
// Operand/result bundle between the parent and the adder stage.
// The ovf signal exists only when ADDER_OVERFLOW_EN is defined.
interface four_bit_ripple_adder_if;
   import adder_pkg::*;

   logic    in_valid;
   nibble_t a;
   nibble_t b;
   logic    cin;
   logic    out_valid;
   nibble_t s;
   logic    cout;
`ifdef ADDER_OVERFLOW_EN
   logic    ovf;
`endif

   modport master (
      output in_valid, a, b, cin,
`ifdef ADDER_OVERFLOW_EN
      input  ovf,
`endif
      input  out_valid, s, cout
   );

   modport slave (
      input  in_valid, a, b, cin,
`ifdef ADDER_OVERFLOW_EN
      output ovf,
`endif
      output out_valid, s, cout
   );

endinterface

// File: rtl/four_bit_ripple_adder_fa.sv
// Single-bit full adder; one cell per bit of the ripple chain.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic halfSum;

   assign halfSum = a ^ b;
   assign s       = halfSum ^ ci;
   assign co      = (a & b) | (ci & halfSum);

endmodule

// File: rtl/four_bit_ripple_adder.sv
// Registered 4-bit ripple-carry adder with one-cycle latency and valid tracking.
// Define ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module four_bit_ripple_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   four_bit_ripple_adder_if.slave  bus
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sumComb;

   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             cout_q;
   logic             cout_d;
   logic             valid_q;

   assign carry[0] = bus.cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_cell u_cell (
         .a  (bus.a[i]),
         .b  (bus.b[i]),
         .ci (carry[i]),
         .s  (sumComb[i]),
         .co (carry[i+1])
      );
   end

   // Results load only on valid cycles so idle-cycle operands never reach the outputs.
   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
      if (bus.in_valid) begin
         sum_d  = sumComb;
         cout_d = carry[WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         valid_q <= bus.in_valid;
      end
   end

   assign bus.s         = sum_q;
   assign bus.cout      = cout_q;
   assign bus.out_valid = valid_q;

`ifdef ADDER_OVERFLOW_EN
   logic ovf_q;
   logic ovf_d;

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   always_comb begin
      ovf_d = ovf_q;
      if (bus.in_valid) begin
         ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_ripple_adder.sv
// Scoreboard bench for four_bit_ripple_adder; define ADDER_OVERFLOW_EN to also check ovf.
module tb_four_bit_ripple_adder;
   import adder_pkg::*;

   typedef struct {
      logic        valid;
      add_result_t res;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;

   four_bit_ripple_adder_if bus ();

   four_bit_ripple_adder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          compared;
   int          mismatched;
   exp_t        expQ[$];
   exp_t        monE;
   add_result_t lastRes;
   logic        lastOvf;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Plain integer arithmetic: the sum as a 5-bit value split into carry and nibble.
   function automatic add_result_t refAdd(int x, int y, int c);
      add_result_t r;
      int total;
      total  = x + y + c;
      r.s    = nibble_t'(total % 16);
      r.cout = (total >= 16);
      return r;
   endfunction

   function automatic logic refOvf(int x, int y, int c);
      int sx;
      int sy;
      int t;
      sx = (x >= 8) ? x - 16 : x;
      sy = (y >= 8) ? y - 16 : y;
      t  = sx + sy + c;
      return (t > 7) || (t < -8);
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input int x, input int y, input int c);
      exp_t e;
      @(negedge clk);
      #1;
      bus.in_valid = v;
      bus.a        = nibble_t'(x);
      bus.b        = nibble_t'(y);
      bus.cin      = c[0];
      if (v) begin
         lastRes = refAdd(x, y, c);
         lastOvf = refOvf(x, y, c);
      end
      e.valid = v;
      e.res   = lastRes;
      e.ovf   = lastOvf;
      expQ.push_back(e);
   endtask

   // Monitor: each entry describes the outputs expected after the following rising edge.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         checkOutput("out_valid", {7'd0, bus.out_valid}, {7'd0, monE.valid});
         checkOutput("s", {4'd0, bus.s}, {4'd0, monE.res.s});
         checkOutput("cout", {7'd0, bus.cout}, {7'd0, monE.res.cout});
`ifdef ADDER_OVERFLOW_EN
         checkOutput("ovf", {7'd0, bus.ovf}, {7'd0, monE.ovf});
`endif
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int order[512];
      int tmp;
      int j;
      compared     = 0;
      mismatched   = 0;
      lastRes      = '0;
      lastOvf      = 1'b0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.cin      = 1'b0;

      #3;
      checkOutput("reset_s", {4'd0, bus.s}, 8'd0);
      checkOutput("reset_cout", {7'd0, bus.cout}, 8'd0);
      checkOutput("reset_valid", {7'd0, bus.out_valid}, 8'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Directed cases: plain add, wrap-around, subtraction via ~b and cin=1, signed overflow.
      applyStimulus(1'b1, 4'b1000, 4'b0010, 0);
      applyStimulus(1'b1, 4'b1000, 4'b1000, 0);
      applyStimulus(1'b1, 4'b1110, 4'b1111, 0);
      applyStimulus(1'b1, 4'b1111, 4'b0001, 0);
      applyStimulus(1'b1, 4'b1000, 4'b1101, 1);
      applyStimulus(1'b1, 4'b0010, 4'b0111, 1);
      applyStimulus(1'b1, 4'b0111, 4'b0001, 0);
      applyStimulus(1'b1, 4'b1010, 4'b1101, 0);
      applyStimulus(1'b0, 4'b0101, 4'b0101, 1);
      applyStimulus(1'b0, 4'b0011, 4'b1100, 0);

      // Asynchronous reset between edges while a result is being presented.
      applyStimulus(1'b1, 4'b1001, 4'b1001, 1);
      @(negedge clk);
      #2;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checkOutput("async_rst_s", {4'd0, bus.s}, 8'd0);
      checkOutput("async_rst_cout", {7'd0, bus.cout}, 8'd0);
      checkOutput("async_rst_valid", {7'd0, bus.out_valid}, 8'd0);
`ifdef ADDER_OVERFLOW_EN
      checkOutput("async_rst_ovf", {7'd0, bus.ovf}, 8'd0);
`endif
      lastRes = '0;
      lastOvf = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (3) applyStimulus(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));

      // All 512 operand combinations back-to-back in shuffled order.
      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         j        = $urandom_range(0, i);
         tmp      = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 512; i++) begin
         applyStimulus(1'b1, (order[i] >> 5) & 15, (order[i] >> 1) & 15, order[i] & 1);
      end

      // Random valid gaps exercise the hold behaviour.
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 1));
      end
      applyStimulus(1'b0, 0, 0, 0);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      #1;
      checkOutput("drain", {7'd0, expQ.size() == 0}, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
